// File: rtl/copro_result_buffer.sv
// Queues the ALU's unstoppable result pulses and replays them to the core over a valid/ready channel.
// Credits throttle issue so that a FIFO slot is always free when the matching result arrives.
module copro_result_buffer #(
    parameter int unsigned Depth = 4,
    parameter int unsigned XLEN  = 32,
    parameter type         hartid_t = logic,
    parameter type         id_t     = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       issue_fire_i,
    output logic                       issue_ready_o,
    input  logic                       alu_valid_i,
    input  logic [XLEN-1:0]            alu_result_i,
    input  hartid_t                    alu_hartid_i,
    input  id_t                        alu_id_i,
    input  logic [4:0]                 alu_rd_i,
    input  logic                       alu_we_i,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic [XLEN-1:0]            result_data_o,
    output hartid_t                    result_hartid_o,
    output id_t                        result_id_o,
    output logic [4:0]                 result_rd_o,
    output logic                       result_we_o,
    output logic                       overflow_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth+1);

    typedef struct packed {
        logic [XLEN-1:0] data;
        hartid_t         hartid;
        id_t             id;
        logic [4:0]      rd;
        logic            we;
    } entry_t;

    entry_t          mem_q [Depth];
    entry_t          mem_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] credits_q, credits_d;
    logic            overflow_q, overflow_d;

    logic   full;
    logic   pop;
    logic   push_ok;
    logic   fire_ok;
    entry_t alu_entry;
    entry_t head;

    assign full    = (count_q == CntW'(Depth));
    assign pop     = (count_q != '0) && result_ready_i;
    // A pop in the same cycle frees the slot, so a push onto a full FIFO is still legal then.
    assign push_ok = alu_valid_i && (!full || pop);
    assign fire_ok = issue_fire_i && (credits_q != '0);

    assign alu_entry = '{data: alu_result_i, hartid: alu_hartid_i, id: alu_id_i,
                         rd: alu_rd_i, we: alu_we_i};

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        credits_d  = credits_q;
        overflow_d = overflow_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = alu_entry;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        if (push_ok && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CntW'(1);
        end

        // A returned slot and a newly issued instruction cancel each other out.
        if (pop && !fire_ok) begin
            credits_d = credits_q + CntW'(1);
        end else if (fire_ok && !pop) begin
            credits_d = credits_q - CntW'(1);
        end

        if (alu_valid_i && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            credits_q  <= CntW'(Depth);
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            credits_q  <= credits_d;
            overflow_q <= overflow_d;
        end
    end

    assign head            = mem_q[rd_ptr_q];
    assign result_valid_o  = (count_q != '0);
    assign result_data_o   = head.data;
    assign result_hartid_o = head.hartid;
    assign result_id_o     = head.id;
    assign result_rd_o     = head.rd;
    assign result_we_o     = head.we;
    assign issue_ready_o   = (credits_q != '0);
    assign overflow_o      = overflow_q;
    assign count_o         = count_q;

    // More credits than slots means the core popped a result that was never issued.
    assert property (@(posedge clk_i) disable iff (!rst_ni) credits_q <= CntW'(Depth));

endmodule

// File: doc/copro_result_buffer.md
Name: copro_result_buffer

Overview:
- Consumer side of the coprocessor ALU's registered result outputs; drives the CV-X-IF result channel back to the core.
- ALU results arrive as one-cycle valid pulses and cannot be back-pressured, so results are queued in a FIFO and presented with a valid/ready handshake.
- A credit counter gates instruction issue (issue_ready_o) so that every ALU result is guaranteed a free FIFO slot.

Parameters:
- Depth, 4, FIFO entries; power of two, >= 2.
- XLEN, 32, result width.
- hartid_t, logic, hart ID type, passed through unchanged.
- id_t, logic, instruction ID type, passed through unchanged.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- issue_fire_i  in  1  an instruction enters the ALU this cycle; consumes one credit
- issue_ready_o  out  1  at least one credit is available
- alu_valid_i  in  1  ALU result valid pulse
- alu_result_i  in  XLEN  ALU result
- alu_hartid_i  in  hartid_t  ALU hart ID
- alu_id_i  in  id_t  ALU instruction ID
- alu_rd_i  in  5  destination register
- alu_we_i  in  1  register write enable
- result_valid_o  out  1  FIFO head is valid
- result_ready_i  in  1  core accepts the head entry
- result_data_o  out  XLEN  head result
- result_hartid_o  out  hartid_t  head hart ID
- result_id_o  out  id_t  head instruction ID
- result_rd_o  out  5  head destination register
- result_we_o  out  1  head write enable
- overflow_o  out  1  sticky error: push attempted while full with no simultaneous pop
- count_o  out  $clog2(Depth+1)  current FIFO occupancy

Behaviour:
- Reset (async, active-low) clears all state, including mid-operation, and flushes in-flight entries:
  - wr_ptr = 0, rd_ptr = 0, count = 0, credits = Depth, overflow = 0.
  - Outputs during reset: result_valid_o = 0, issue_ready_o = 1, overflow_o = 0, count_o = 0.
  - Data outputs are 0 (storage array is reset).
- Push: alu_valid_i = 1 writes {result, hartid, id, rd, we} at wr_ptr; wr_ptr increments modulo Depth.
- Pop: result_valid_o && result_ready_i; rd_ptr increments modulo Depth.
- Every entry is pushed and presented, including we = 0 entries (NOP); the core needs a result for each offloaded instruction.
- Latency: a push in cycle N gives result_valid_o = 1 in cycle N+1 when the FIFO was empty. There is no combinational bypass.
- Output stability:
  - result_valid_o = (count != 0).
  - Head outputs read combinationally from storage[rd_ptr].
  - Head fields stay stable while valid && !ready.
- Count update per cycle: count += push_ok - pop.
  - push_ok = alu_valid_i && (count < Depth || pop).
  - With push and pop in the same cycle, count is unchanged (allowed even when full).
- Overflow: alu_valid_i && count == Depth && !pop sets overflow_o (sticky until reset). The data is dropped and pointers and count do not move.
- Credits, range 0..Depth:
  - Per cycle: credits += pop - (issue_fire_i && credits != 0).
  - issue_ready_o = (credits != 0).
  - issue_fire_i while credits == 0 is ignored, with no wrap below 0.
  - Pop and fire in the same cycle leave credits unchanged.
  - Credits never exceed Depth; an assertion enforces this in simulation.
- Invariant: credits + count + in-flight ALU ops == Depth. This holds because the ALU has fixed 1-cycle latency and one result per issue.
- Pointer wrap: pointers are $clog2(Depth) bits and wrap naturally from Depth-1 to 0.
- Implementation is pure sequential storage plus counters; no state machine beyond count/credit registers.

Test Plan:
- Reset, then issue_fire_i for 1 cycle; next cycle alu_valid_i with result 0x0000_00AA, rd 5, we 1, result_ready_i = 1 -> result_valid_o = 1 exactly one cycle after the push with data 0xAA and rd 5; credits return to 4 after the pop.
- Depth = 4, result_ready_i held 0: issue 4 instructions and push results 0x1..0x4 -> issue_ready_o = 0 after the 4th fire; count_o = 4; head shows 0x1 and stays stable. Raise ready -> outputs 0x1, 0x2, 0x3, 0x4 in order on consecutive cycles; issue_ready_o reasserts the cycle after the first pop.
- Full FIFO (count 4), same cycle alu_valid_i with 0x5 and result_ready_i = 1 -> 0x1 popped, 0x5 stored, count stays 4, overflow_o stays 0. Later drain -> 0x2, 0x3, 0x4, 0x5 (pointer wrap verified).
- Full FIFO, alu_valid_i with 0xDEAD and result_ready_i = 0 -> overflow_o = 1 (sticky); count stays 4; 0xDEAD is never presented.
- NOP result (we = 0, rd = 0, id 3) -> presented with result_we_o = 0 and result_id_o = 3; the credit is returned on pop.
- 3 entries queued and overflow_o = 1, assert rst_ni low mid-operation -> result_valid_o = 0, count_o = 0, issue_ready_o = 1, overflow_o = 0 asynchronously. After release, a new push appears as the first result.
